// File: rtl/ring_johnson_decoder.sv
// ---------------------------------------------------------------------------
// ring_johnson_decoder
//
// Receive-side companion to the ring/Johnson counter generator. Decodes the
// sampled code word into a phase index, checks legality and step order, and
// runs a HUNT / CHECK / LOCKED lock machine so downstream logic gets a phase
// it can trust together with a lock flag and a one-cycle fault pulse.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset, overrides everything
//   m          code mode: 0 = ring, 1 = Johnson (must match the generator)
//   din        sampled code word (WIDTH bits)
//   din_vld    din is a new sample to evaluate this cycle
//   phase      decoded phase index of the last legal word (PW bits)
//   phase_vld  last evaluated din was a legal code word
//   locked     sequence lock achieved
//   err        one-cycle pulse on a step or legality fault while locked
//   err_cnt    saturating count of err pulses (only with RJ_DEC_ERR_COUNT_EN)
//
// Optional feature macro: RJ_DEC_ERR_COUNT_EN adds the err_cnt output.
// All outputs are registered: din sampled at edge n is visible after edge n.
// ---------------------------------------------------------------------------
module ring_johnson_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    localparam int PW      = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             m,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [PW-1:0]    phase,
    output logic             phase_vld,
    output logic             locked,
`ifdef RJ_DEC_ERR_COUNT_EN
    output logic             err,
    output logic [7:0]       err_cnt
`else
    output logic             err
`endif
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int CW = $clog2(LOCK_CNT + 1);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]    state;
    logic [CW-1:0] cnt;     // consecutive in-sequence words since HUNT
    logic          m_q;

    logic          dec_legal;
    logic [PW-1:0] dec_phase;
    logic [PW-1:0] next_phase;
    logic          correct_step;
    logic          mode_chg;
    logic          fault_locked;

    // -----------------------------------------------------------------------
    // Combinational decode of din under the current mode
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // through the loops can leave a value unassigned and infer a latch.
    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        if (!m) begin
            // Ring: single one, walking from the MSB towards the LSB.
            for (int k = 0; k < WIDTH; k++) begin
                if (din == (MSB >> k)) begin
                    dec_legal = 1'b1;
                    dec_phase = PW'(k);
                end
            end
        end else begin
            // Johnson first half: k leading ones (k = 0 gives all zeros).
            for (int k = 0; k <= WIDTH; k++) begin
                if (din == ~(ONES >> k)) begin
                    dec_legal = 1'b1;
                    dec_phase = PW'(k);
                end
            end
            // Johnson second half: j trailing ones count down to the wrap.
            for (int j = 1; j < WIDTH; j++) begin
                if (din == (ONES >> (WIDTH - j))) begin
                    dec_legal = 1'b1;
                    dec_phase = PW'(2 * WIDTH - j);
                end
            end
        end
    end

    // Successor of the stored phase, wrapping at the mode's cycle length.
    always_comb begin
        if (phase == (m ? PW'(2 * WIDTH - 1) : PW'(WIDTH - 1)))
            next_phase = '0;
        else
            next_phase = phase + PW'(1);
    end

    assign correct_step = dec_legal && (dec_phase == next_phase);
    assign mode_chg     = (m != m_q);
    // A mode change outranks a simultaneous fault, so it masks the pulse.
    assign fault_locked = din_vld && !mode_chg && (state == LOCKED) && !correct_step;

    // -----------------------------------------------------------------------
    // Lock state machine and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= HUNT;
            cnt       <= '0;
            m_q       <= 1'b0;
            phase     <= '0;
            phase_vld <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            m_q <= m;
            err <= fault_locked;

            if (mode_chg) begin
                // Sample is discarded; phase and phase_vld keep their values.
                state  <= HUNT;
                cnt    <= '0;
                locked <= 1'b0;
            end else if (din_vld) begin
                // An illegal word keeps the last good phase for reference.
                if (dec_legal) begin
                    phase     <= dec_phase;
                    phase_vld <= 1'b1;
                end else begin
                    phase_vld <= 1'b0;
                end

                case (state)
                    HUNT: begin
                        if (dec_legal) begin
                            state <= CHECK;
                            cnt   <= CW'(1);
                        end
                    end
                    CHECK: begin
                        if (!dec_legal) begin
                            state <= HUNT;
                            cnt   <= '0;
                        end else if (correct_step) begin
                            // cnt counts words, so LOCK_CNT correct steps
                            // have been seen once cnt already equals LOCK_CNT.
                            if (cnt == CW'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt <= CW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!correct_step) begin
                            state  <= HUNT;
                            cnt    <= '0;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        cnt    <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RJ_DEC_ERR_COUNT_EN
    // Saturating fault counter, cleared only by clr.
    always_ff @(posedge clk) begin
        if (clr)
            err_cnt <= '0;
        else if (fault_locked && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_ring_johnson_decoder.sv
// ---------------------------------------------------------------------------
// tb_ring_johnson_decoder
//
// Table of directed vectors, hand-written corner sequences and a randomized
// run checked against a behavioural model built from the generator's own
// stepping rules (ring rotate / Johnson twisted shift).
// ---------------------------------------------------------------------------
module tb_ring_johnson_decoder;

    localparam int W   = 4;
    localparam int LCK = 3;

    logic       clk     = 1'b0;
    logic       clr     = 1'b1;
    logic       m       = 1'b0;
    logic [3:0] din     = 4'b0000;
    logic       din_vld = 1'b0;
    logic [2:0] phase;
    logic       phase_vld;
    logic       locked;
    logic       err;
`ifdef RJ_DEC_ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    ring_johnson_decoder #(.WIDTH(W), .LOCK_CNT(LCK)) dut (
        .clk       (clk),
        .clr       (clr),
        .m         (m),
        .din       (din),
        .din_vld   (din_vld),
        .phase     (phase),
        .phase_vld (phase_vld),
        .locked    (locked),
`ifdef RJ_DEC_ERR_COUNT_EN
        .err       (err),
        .err_cnt   (err_cnt)
`else
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [3:0] ring_tab [W];
    logic [3:0] john_tab [2*W];

    int md_phase, md_run, md_errcnt;
    bit md_pvld, md_locked, md_err, md_mprev;

    task automatic build_tables();
        logic [3:0] w;
        w = 4'b1000;
        for (int k = 0; k < W; k++) begin
            ring_tab[k] = w;
            w = {w[0], w[3:1]};          // ring generator: rotate right
        end
        w = 4'b0000;
        for (int k = 0; k < 2*W; k++) begin
            john_tab[k] = w;
            w = {~w[0], w[3:1]};         // Johnson generator: twisted shift
        end
    endtask

    task automatic model_step(input bit c, input bit mm, input logic [3:0] d, input bit v);
        int  n, k;
        bit  legal, succ;
        if (c) begin
            md_phase = 0; md_pvld = 0; md_locked = 0; md_err = 0;
            md_run = 0; md_mprev = 0; md_errcnt = 0;
            return;
        end
        md_err = 0;
        if (mm != md_mprev) begin
            md_mprev  = mm;
            md_locked = 0;
            md_run    = 0;
            return;
        end
        if (!v) return;
        n = mm ? 2*W : W;
        legal = 0; k = 0;
        for (int i = 0; i < n; i++) begin
            if ((mm ? john_tab[i] : ring_tab[i]) == d) begin
                legal = 1; k = i;
            end
        end
        succ = legal && (md_run > 0) && (k == (md_phase + 1) % n);
        if (md_locked && !succ) begin
            md_err = 1; md_locked = 0; md_run = 0;
            if (md_errcnt < 255) md_errcnt++;
        end else if (!md_locked) begin
            if (!legal)     md_run = 0;
            else if (succ)  md_run++;
            else            md_run = 1;
            if (md_run > LCK) md_locked = 1;   // LCK correct steps after first word
        end
        md_pvld = legal;
        if (legal) md_phase = k;
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit c, input bit mm, input logic [3:0] d, input bit v);
        clr = c; m = mm; din = d; din_vld = v;
        @(posedge clk);
        model_step(c, mm, d, v);
        #1;
    endtask

    task automatic expect_out(input string tag, input int ph, input bit pv,
                              input bit lk, input bit er);
        check({tag, ".phase"},     int'(phase),     ph);
        check({tag, ".phase_vld"}, int'(phase_vld), int'(pv));
        check({tag, ".locked"},    int'(locked),    int'(lk));
        check({tag, ".err"},       int'(err),       int'(er));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         c;
        bit         mm;
        logic [3:0] d;
        bit         v;
        int         ph;
        bit         pv;
        bit         lk;
        bit         er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit c, input bit mm, input logic [3:0] d, input bit v,
                       input int ph, input bit pv, input bit lk, input bit er);
        vec_t e;
        e.c = c; e.mm = mm; e.d = d; e.v = v;
        e.ph = ph; e.pv = pv; e.lk = lk; e.er = er;
        vecs.push_back(e);
    endtask

`ifdef RJ_DEC_ERR_COUNT_EN
    task automatic fault_once();
        step(0, 0, 4'b1000, 1);
        step(0, 0, 4'b0100, 1);
        step(0, 0, 4'b0010, 1);
        step(0, 0, 4'b0001, 1);
        step(0, 0, 4'b0000, 1);
    endtask
`endif

    initial begin
        int         gen_idx, n, r;
        bit         rm;
        logic [3:0] rd;
        build_tables();

        //   clr m  din      vld | phase pvld lock err
        add(1, 0, 4'b1000, 1,   0, 0, 0, 0);   // reset held
        add(1, 0, 4'b1000, 1,   0, 0, 0, 0);
        add(0, 0, 4'b1000, 1,   0, 1, 0, 0);   // ring lock
        add(0, 0, 4'b0100, 1,   1, 1, 0, 0);
        add(0, 0, 4'b0010, 1,   2, 1, 0, 0);
        add(0, 0, 4'b0001, 1,   3, 1, 1, 0);
        add(0, 0, 4'b1000, 1,   0, 1, 1, 0);   // ring wrap 3->0
        add(0, 0, 4'b0100, 1,   1, 1, 1, 0);
        add(0, 0, 4'b0110, 1,   1, 0, 0, 1);   // illegal while locked
        add(0, 0, 4'b0010, 1,   2, 1, 0, 0);
        add(0, 0, 4'b0001, 1,   3, 1, 0, 0);
        add(0, 0, 4'b1000, 1,   0, 1, 0, 0);
        add(0, 0, 4'b0100, 1,   1, 1, 1, 0);   // relock
        add(0, 0, 4'b0010, 1,   2, 1, 1, 0);
        add(0, 1, 4'b0000, 1,   2, 1, 0, 0);   // mode change discards sample
        add(0, 1, 4'b0000, 1,   0, 1, 0, 0);   // Johnson lock
        add(0, 1, 4'b1000, 1,   1, 1, 0, 0);
        add(0, 1, 4'b1100, 1,   2, 1, 0, 0);
        add(0, 1, 4'b1110, 1,   3, 1, 1, 0);
        add(0, 1, 4'b1111, 1,   4, 1, 1, 0);
        add(0, 1, 4'b0111, 1,   5, 1, 1, 0);
        add(0, 1, 4'b0011, 1,   6, 1, 1, 0);
        add(0, 1, 4'b0001, 1,   7, 1, 1, 0);
        add(0, 1, 4'b0000, 1,   0, 1, 1, 0);   // Johnson wrap 7->0
        add(0, 1, 4'b1010, 0,   0, 1, 1, 0);   // no evaluation
        add(0, 1, 4'b1010, 1,   0, 0, 0, 1);   // illegal Johnson word
        add(0, 1, 4'b1000, 0,   0, 0, 0, 0);   // err gone, pvld held

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].mm, vecs[i].d, vecs[i].v);
            expect_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].pv, vecs[i].lk, vecs[i].er);
        end

        // ---- skip and hold faults in Johnson mode ----
        step(1, 1, 4'b0000, 1);
        step(0, 1, 4'b0111, 1);                // mode differs from reset value
        expect_out("jmode_discard", 0, 0, 0, 0);
        step(0, 1, 4'b0111, 1);
        step(0, 1, 4'b0011, 1);
        step(0, 1, 4'b0001, 1);
        step(0, 1, 4'b0000, 1);
        step(0, 1, 4'b1000, 1);
        step(0, 1, 4'b1100, 1);
        expect_out("j_locked_p2", 2, 1, 1, 0);
        step(0, 1, 4'b1111, 1);
        expect_out("j_skip", 4, 1, 0, 1);
        step(0, 1, 4'b0111, 1);
        expect_out("j_skip_after", 5, 1, 0, 0);
        step(0, 1, 4'b0011, 1);
        step(0, 1, 4'b0001, 1);
        step(0, 1, 4'b0000, 1);
        step(0, 1, 4'b1000, 1);
        step(0, 1, 4'b1100, 1);
        expect_out("j_relock", 2, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 4'b1111, 0);
            expect_out($sformatf("j_hold%0d", i), 2, 1, 1, 0);
        end
        step(0, 1, 4'b1100, 1);
        expect_out("j_repeat", 2, 1, 0, 1);

        // ---- clr mid-lock, then mode change coinciding with a fault ----
        step(1, 0, 4'b1000, 1);
        step(0, 0, 4'b1000, 1);
        step(0, 0, 4'b0100, 1);
        step(0, 0, 4'b0010, 1);
        step(0, 0, 4'b0001, 1);
        expect_out("r_locked", 3, 1, 1, 0);
        step(1, 0, 4'b0010, 1);
        expect_out("clr_midlock", 0, 0, 0, 0);
        step(0, 0, 4'b0100, 1);
        expect_out("after_clr", 1, 1, 0, 0);
        step(0, 0, 4'b0010, 1);
        step(0, 0, 4'b0001, 1);
        step(0, 0, 4'b1000, 1);
        expect_out("r_relock", 0, 1, 1, 0);
        step(0, 1, 4'b0110, 1);
        expect_out("mode_and_fault", 0, 1, 0, 0);

`ifdef RJ_DEC_ERR_COUNT_EN
        step(1, 0, 4'b0000, 0);
        check("err_cnt.reset", int'(err_cnt), 0);
        for (int i = 0; i < 3; i++) fault_once();
        check("err_cnt.3", int'(err_cnt), 3);
        for (int i = 0; i < 297; i++) fault_once();
        check("err_cnt.sat", int'(err_cnt), 255);
`endif

        // ---- randomized run against the model ----
        step(1, 0, 4'b0000, 0);
        rm = 0; gen_idx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 59) == 0) rm = ~rm;
            n = rm ? 2*W : W;
            r = $urandom_range(0, 9);
            if (r < 7)       gen_idx++;
            else if (r == 9) gen_idx += 2;
            rd = rm ? john_tab[gen_idx % n] : ring_tab[gen_idx % n];
            if (r == 7) rd = 4'($urandom);
            step($urandom_range(0, 199) == 0, rm, rd, $urandom_range(0, 3) != 0);
            check($sformatf("rnd%0d.outs", cyc),
                  int'({phase, phase_vld, locked, err}),
                  int'({3'(md_phase), md_pvld, md_locked, md_err}));
`ifdef RJ_DEC_ERR_COUNT_EN
            check($sformatf("rnd%0d.err_cnt", cyc), int'(err_cnt), md_errcnt);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_johnson_decoder.md
Name: ring_johnson_decoder

Overview:
- Receive-side companion to the 4-bit ring/Johnson counter generator: samples a ring or Johnson code word, decodes it to a binary phase index, and checks code legality and step sequence.
- Runs a HUNT/CHECK/LOCKED lock state machine, so downstream logic gets a decoded phase plus a trustworthy lock/error indication.
- Sits after the counter output, or after any link carrying the counter word, in the same clock domain.

Parameters:
- WIDTH, 4, code word width.
- LOCK_CNT, 3, consecutive correct steps required to enter LOCKED (range 1..15).
- PW, derived localparam = clog2(2*WIDTH), phase index width (3 for WIDTH=4).

Ports:
- clk, input, 1, rising-edge clock.
- clr, input, 1, synchronous active-high reset.
- m, input, 1, code mode: 0 = ring, 1 = Johnson; must match the generator.
- din, input, WIDTH, sampled code word.
- din_vld, input, 1, din is a new sample to evaluate this cycle.
- phase, output, PW, decoded phase index.
- phase_vld, output, 1, last evaluated din was a legal code word.
- locked, output, 1, sequence lock achieved.
- err, output, 1, one-cycle pulse on a sequence or legality fault while locked.

Behaviour:
- Clock and reset:
  - Single clock.
  - clr is synchronous and active-high; it overrides everything.
  - Reset values: phase=0, phase_vld=0, locked=0, err=0, state=HUNT, step count=0, stored m=0 (optional err_cnt=0).
- Ring code (m=0):
  - Legal words have exactly one 1. The 1 at bit WIDTH-1-k gives phase k (1000→0, 0100→1, 0010→2, 0001→3).
  - N = WIDTH.
- Johnson code (m=1):
  - Legal words are 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7. In general, k leading ones for k≤WIDTH, then a trailing-ones pattern.
  - N = 2*WIDTH.
- Decode is combinational on din. All outputs are registered with 1-cycle latency: din sampled at edge n appears on outputs after edge n.
- When din_vld=0:
  - All state holds.
  - err=0 and phase_vld holds.
  - No evaluation.
- A correct step means din is legal and its phase == (previous phase + 1) mod N. Wrap-around is included, e.g. Johnson 7→0 and ring 3→0.
- State machine (evaluated only when din_vld=1):
  - HUNT: a legal din stores its phase, sets count=1, and moves to CHECK. An illegal din stays in HUNT.
  - CHECK:
    - A correct step increments count. When count reaches LOCK_CNT, move to LOCKED and set locked=1 on the same registered update.
    - A legal but wrong step stores the new phase and restarts count=1.
    - An illegal din returns to HUNT with count=0.
  - LOCKED:
    - A correct step stays in LOCKED.
    - A repeated phase, skipped phase or illegal word pulses err=1 for one cycle, clears locked, and goes to HUNT.
- With LOCK_CNT=1, LOCKED is entered on the first correct step after the first legal word.
- Mode change: m is registered each cycle. If m differs from its registered value, the same-cycle sample is discarded, state goes to HUNT, locked clears, and no err pulse is issued.
- Simultaneous mode change and fault: the mode change wins, so there is no err.
- clr asserted mid-lock drops locked on the next edge. The first sample after clr release can only enter CHECK.
- An illegal din sets phase_vld=0 and holds the previous phase value.

Optional Feature:
- Macro RJ_DEC_ERR_COUNT_EN.
- When defined, the block adds output err_cnt [7:0]:
  - increments on each err pulse;
  - saturates at 255;
  - clears only on clr.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold clr=1 for 2 cycles with din=1000 and din_vld=1 → phase=0, phase_vld=0, locked=0, err=0 throughout.
- Ring lock: m=0, din_vld=1, din sequence 1000,0100,0010,0001 → phase 0,1,2,3; locked=1 after the 4th sample (LOCK_CNT=3). Continuing with 1000 gives phase=0 with locked still 1 (wrap).
- Johnson lock and wrap: m=1, din sequence 0000,1000,1100,1110,1111,0111,0011,0001,0000 → phase 0..7 then 0. locked=1 from the 4th sample onward, err never asserted.
- Fault while locked: locked in ring mode at phase 1, then inject din=0110 → err=1 for exactly one cycle, locked=0, phase_vld=0. Next samples 0010,0001,1000,0100 → relock after the 4th.
- Skip and hold faults: locked in Johnson mode at phase 2 (1100):
  - din=1111 (skip) → err pulse, HUNT.
  - Relock, then hold din_vld=0 for 5 cycles → no change.
  - Then repeat the same word → err pulse.
- Mode switch and counter: locked in ring mode, toggle m to 1 → locked=0, err=0. With RJ_DEC_ERR_COUNT_EN, after 3 fault pulses err_cnt=3; after 300 fault pulses err_cnt=255.
